sm_para_1_drv: RTL and testbench

SM_PARA_1_DRV -- requirements
Module: sm_para_1_drv

---
 rtl/sm_para_1_drv.sv | 221 ++++++++++++++++++++++
 tb/tb_sm_para_1_drv.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_para_1_drv.sv
// Sequence driver for the IDLE/S1/S2/ERROR partner FSM: walks the partner through
// a programmable number of rounds and checks its registered responses two cycles later.
module sm_para_1_drv #(
    parameter int HOLD_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [HOLD_W-1:0] hold_len,
    input  logic [HOLD_W-1:0] rounds,
    input  logic              inject_err,
    input  logic              o1,
    input  logic              o2,
    input  logic              err,
    output logic              i1,
    output logic              i2,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic              err_seen
);

    typedef enum logic [3:0] {
        D_IDLE, D_ENTER, D_HOLD1, D_ADV, D_HOLD2, D_EXIT, D_DRAIN, D_RECOV, D_DONE
    } state_t;

    localparam logic [HOLD_W-1:0] ONE     = HOLD_W'(1);
    localparam logic [2:0]        EXP_S1  = 3'b100;
    localparam logic [2:0]        EXP_S2  = 3'b010;
    localparam logic [2:0]        EXP_IDL = 3'b000;
    localparam logic [2:0]        EXP_ERR = 3'b111;

    state_t            state;
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hcnt;
    logic [HOLD_W-1:0] rcnt;
    logic              inj_q;
    logic [1:0]        aux;
    logic              s1_v;
    logic              s2_v;
    logic [2:0]        s1_exp;
    logic [2:0]        s2_exp;
    logic [2:0]        resp;
    logic              mismatch;
    logic              err_hit;

    assign resp     = {o1, o2, err};
    assign mismatch = s2_v && (s2_exp != resp);
    assign err_hit  = s2_v && (s2_exp == EXP_ERR) && (resp == EXP_ERR);

    // Each drive loads i1/i2 together with the state it belongs to, and pushes its
    // expected partner code into stage 1; stage 2 is compared on the following edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= D_IDLE;
            i1       <= 1'b0;
            i2       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            fail     <= 1'b0;
            err_seen <= 1'b0;
            hold_q   <= '0;
            hcnt     <= '0;
            rcnt     <= '0;
            inj_q    <= 1'b0;
            aux      <= '0;
            s1_v     <= 1'b0;
            s2_v     <= 1'b0;
            s1_exp   <= '0;
            s2_exp   <= '0;
        end else begin
            done   <= 1'b0;
            s2_v   <= s1_v;
            s2_exp <= s1_exp;
            s1_v   <= 1'b0;
            if (err_hit) err_seen <= 1'b1;
            case (state)
                D_IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        fail     <= 1'b0;
                        err_seen <= 1'b0;
                        hold_q   <= hold_len;
                        rcnt     <= (rounds == '0) ? ONE : rounds;
                        inj_q    <= inject_err;
                        s2_v     <= 1'b0;
                        s1_v     <= 1'b1;
                        state    <= D_ENTER;
                        i1       <= 1'b1;
                        i2       <= !inject_err;
                        s1_exp   <= inject_err ? EXP_ERR : EXP_S1;
                    end
                end
                D_DRAIN: begin
                    if (mismatch) fail <= 1'b1;
                    i1 <= 1'b0;
                    i2 <= 1'b0;
                    if (aux == 2'd1) begin
                        state <= D_DONE;
                        done  <= 1'b1;
                    end else begin
                        aux <= aux + 2'd1;
                    end
                end
                // Recovery ignores responses, apart from the injected-error code still in flight.
                D_RECOV: begin
                    i1 <= 1'b0;
                    i2 <= 1'b0;
                    if (aux == 2'd2) begin
                        state <= D_DONE;
                        done  <= 1'b1;
                    end else begin
                        aux <= aux + 2'd1;
                    end
                end
                D_DONE: begin
                    state <= D_IDLE;
                    busy  <= 1'b0;
                    i1    <= 1'b0;
                    i2    <= 1'b0;
                end
                default: begin
                    if (mismatch) begin
                        fail  <= 1'b1;
                        s1_v  <= 1'b0;
                        s2_v  <= 1'b0;
                        state <= D_RECOV;
                        aux   <= '0;
                        i1    <= 1'b0;
                        i2    <= 1'b1;
                    end else begin
                        case (state)
                            D_ENTER: begin
                                if (inj_q) begin
                                    inj_q <= 1'b0;
                                    state <= D_RECOV;
                                    aux   <= '0;
                                    i1    <= 1'b0;
                                    i2    <= 1'b1;
                                end else if (hold_q != '0) begin
                                    state  <= D_HOLD1;
                                    hcnt   <= hold_q;
                                    i1     <= 1'b1;
                                    i2     <= 1'b0;
                                    s1_v   <= 1'b1;
                                    s1_exp <= EXP_S1;
                                end else begin
                                    state  <= D_ADV;
                                    i1     <= 1'b1;
                                    i2     <= 1'b1;
                                    s1_v   <= 1'b1;
                                    s1_exp <= EXP_S2;
                                end
                            end
                            D_HOLD1: begin
                                s1_v <= 1'b1;
                                i1   <= 1'b1;
                                if (hcnt == ONE) begin
                                    hcnt   <= '0;
                                    state  <= D_ADV;
                                    i2     <= 1'b1;
                                    s1_exp <= EXP_S2;
                                end else begin
                                    hcnt   <= hcnt - ONE;
                                    i2     <= 1'b0;
                                    s1_exp <= EXP_S1;
                                end
                            end
                            D_ADV: begin
                                s1_v <= 1'b1;
                                i1   <= 1'b1;
                                if (hold_q != '0) begin
                                    state  <= D_HOLD2;
                                    hcnt   <= hold_q;
                                    i2     <= 1'b1;
                                    s1_exp <= EXP_S2;
                                end else begin
                                    state  <= D_EXIT;
                                    i2     <= 1'b0;
                                    s1_exp <= EXP_IDL;
                                end
                            end
                            D_HOLD2: begin
                                s1_v <= 1'b1;
                                i1   <= 1'b1;
                                if (hcnt == ONE) begin
                                    hcnt   <= '0;
                                    state  <= D_EXIT;
                                    i2     <= 1'b0;
                                    s1_exp <= EXP_IDL;
                                end else begin
                                    hcnt   <= hcnt - ONE;
                                    i2     <= 1'b1;
                                    s1_exp <= EXP_S2;
                                end
                            end
                            D_EXIT: begin
                                if (rcnt > ONE) begin
                                    rcnt   <= rcnt - ONE;
                                    state  <= D_ENTER;
                                    i1     <= 1'b1;
                                    i2     <= 1'b1;
                                    s1_v   <= 1'b1;
                                    s1_exp <= EXP_S1;
                                end else begin
                                    rcnt  <= '0;
                                    state <= D_DRAIN;
                                    aux   <= '0;
                                    i1    <= 1'b0;
                                    i2    <= 1'b0;
                                end
                            end
                            default: state <= D_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sm_para_1_drv.sv
// Bench for sm_para_1_drv: a partner FSM model answers the drives, and a per-cycle
// trace built from the round/hold/error rules is compared against every DUT output.
module tb_sm_para_1_drv;

    localparam int HOLD_W = 4;

    typedef enum logic [1:0] {P_IDLE, P_S1, P_S2, P_ERR} pstate_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [HOLD_W-1:0] hold_len;
    logic [HOLD_W-1:0] rounds;
    logic              inject_err;
    logic              o1;
    logic              o2;
    logic              err;
    logic              i1;
    logic              i2;
    logic              busy;
    logic              done;
    logic              fail;
    logic              err_seen;

    pstate_t    pst;
    bit         fault_mode;
    logic [5:0] expq[$];
    logic [5:0] model_q[$];
    bit         last_fail;
    bit         last_err;
    bit         checking;
    int         n_checks;
    int         n_fails;
    int         done_seen;
    int         exp_dones;

    sm_para_1_drv #(.HOLD_W(HOLD_W)) dut (
        .clk(clk), .rst(rst), .start(start), .hold_len(hold_len), .rounds(rounds),
        .inject_err(inject_err), .o1(o1), .o2(o2), .err(err), .i1(i1), .i2(i2),
        .busy(busy), .done(done), .fail(fail), .err_seen(err_seen)
    );

    always #5 clk = ~clk;

    // Partner FSM sharing the DUT reset; fault_mode suppresses o2 while in S2.
    always @(posedge clk) begin
        if (rst) pst <= P_IDLE;
        else begin
            case (pst)
                P_IDLE:  pst <= !i1 ? P_IDLE : (i2 ? P_S1 : P_ERR);
                P_S1:    pst <= !i2 ? P_S1 : (i1 ? P_S2 : P_ERR);
                P_S2:    pst <= i2 ? P_S2 : (i1 ? P_IDLE : P_ERR);
                default: pst <= i1 ? P_ERR : P_IDLE;
            endcase
        end
    end

    always_comb begin
        {o1, o2, err} = 3'b000;
        case (pst)
            P_S1:    {o1, o2, err} = 3'b100;
            P_S2:    {o1, o2, err} = fault_mode ? 3'b000 : 3'b010;
            P_ERR:   {o1, o2, err} = 3'b111;
            default: {o1, o2, err} = 3'b000;
        endcase
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        n_checks++;
        if (actual !== required) begin
            n_fails++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, required, $time);
        end
    endtask

    // Trace record per cycle after start: {i1,i2,busy,done,fail,err_seen}.
    task automatic build_trace(input int r, input int h, input bit inj, input bit flt);
        int         re;
        int         keep;
        logic [1:0] drv[$];
        logic [5:0] last;
        re = (r == 0) ? 1 : r;
        model_q.delete();
        if (inj) begin
            model_q.push_back({2'b10, 4'b1000});
            model_q.push_back({2'b01, 4'b1000});
            model_q.push_back({2'b00, 4'b1001});
            model_q.push_back({2'b00, 4'b1001});
            model_q.push_back({2'b00, 4'b1101});
        end else begin
            for (int k = 0; k < re; k++) begin
                drv.push_back(2'b11);
                for (int j = 0; j < h; j++) drv.push_back(2'b10);
                drv.push_back(2'b11);
                for (int j = 0; j < h; j++) drv.push_back(2'b11);
                drv.push_back(2'b10);
            end
            if (flt) begin
                keep = h + 3;
                for (int k = 0; k < keep; k++) model_q.push_back({drv[k], 4'b1000});
                model_q.push_back({2'b01, 4'b1010});
                model_q.push_back({2'b00, 4'b1010});
                model_q.push_back({2'b00, 4'b1010});
                model_q.push_back({2'b00, 4'b1110});
            end else begin
                foreach (drv[k]) model_q.push_back({drv[k], 4'b1000});
                model_q.push_back({2'b00, 4'b1000});
                model_q.push_back({2'b00, 4'b1000});
                model_q.push_back({2'b00, 4'b1100});
            end
        end
        last      = model_q[model_q.size() - 1];
        last_fail = last[1];
        last_err  = last[0];
    endtask

    always @(negedge clk) begin : cmp
        logic [5:0] e;
        if (checking) begin
            if (expq.size() > 0) e = expq.pop_front();
            else e = {4'b0000, last_fail, last_err};
            checkOutput("outputs", {26'd0, i1, i2, busy, done, fail, err_seen}, {26'd0, e});
            if (done === 1'b1) done_seen++;
        end
    end

    task automatic applyStimulus(input int r, input int h, input bit inj, input bit flt, input bit busy_start);
        int waited;
        @(negedge clk); #1;
        rounds     = HOLD_W'(r);
        hold_len   = HOLD_W'(h);
        inject_err = inj;
        fault_mode = flt;
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
        rounds     = HOLD_W'($urandom_range(0, 15));
        hold_len   = HOLD_W'($urandom_range(0, 15));
        inject_err = 1'($urandom_range(0, 1));
        build_trace(r, h, inj, flt);
        foreach (model_q[k]) expq.push_back(model_q[k]);
        exp_dones++;
        if (busy_start) begin
            repeat (2) @(negedge clk);
            #1 start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        waited = 0;
        while (expq.size() > 0 && waited < 400) begin
            @(negedge clk); #1;
            waited++;
        end
        if (expq.size() > 0) begin
            checkOutput("drain_timeout", 32'(expq.size()), 32'd0);
            expq.delete();
        end
        checkOutput("partner_idle", 32'(pst), 32'(P_IDLE));
        // Start raised during the done cycle must be ignored.
        if (busy_start) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        fault_mode = 1'b0;
    endtask

    task automatic applyMidReset();
        @(negedge clk); #1;
        rounds     = HOLD_W'(2);
        hold_len   = HOLD_W'(3);
        inject_err = 1'b0;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        build_trace(2, 3, 1'b0, 1'b0);
        foreach (model_q[k]) expq.push_back(model_q[k]);
        repeat (7) @(negedge clk);
        #1 rst = 1'b1;
        expq.delete();
        last_fail = 1'b0;
        last_err  = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [11:0] pk;
        bit          inj;
        bit          flt;
        rst        = 1'b1;
        start      = 1'b0;
        rounds     = '0;
        hold_len   = '0;
        inject_err = 1'b0;
        fault_mode = 1'b0;
        checking   = 1'b0;

        build_trace(1, 0, 1'b0, 1'b0);
        checkOutput("model_len_r1h0", 32'(model_q.size()), 32'd6);
        pk = '0;
        for (int k = 0; k < 6; k++) pk = {pk[9:0], model_q[k][5:4]};
        checkOutput("model_drv_r1h0", {20'd0, pk}, {20'd0, 12'b11_11_10_00_00_00});
        checkOutput("model_done_r1h0", {31'd0, model_q[5][2]}, 32'd1);
        build_trace(3, 2, 1'b0, 1'b0);
        checkOutput("model_len_r3h2", 32'(model_q.size()), 32'd24);
        build_trace(0, 1, 1'b1, 1'b0);
        checkOutput("model_len_inj", 32'(model_q.size()), 32'd5);
        checkOutput("model_err_inj", {31'd0, model_q[2][0]}, 32'd1);
        build_trace(1, 0, 1'b0, 1'b1);
        checkOutput("model_len_flt", 32'(model_q.size()), 32'd7);
        checkOutput("model_recov_flt", {26'd0, model_q[3]}, {26'd0, 6'b01_1010});
        model_q.delete();
        last_fail = 1'b0;
        last_err  = 1'b0;

        @(posedge clk); #1;
        checking = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        applyStimulus(1, 0, 1'b0, 1'b0, 1'b0);
        applyStimulus(3, 2, 1'b0, 1'b0, 1'b0);
        applyStimulus(1, 0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1, 0, 1'b0, 1'b1, 1'b0);
        applyStimulus(2, 2, 1'b0, 1'b1, 1'b0);
        applyMidReset();
        applyStimulus(2, 1, 1'b0, 1'b0, 1'b1);
        applyStimulus(0, 0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1, 15, 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 30; n++) begin
            inj = ($urandom_range(0, 3) == 0);
            flt = !inj && ($urandom_range(0, 3) == 0);
            applyStimulus(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), inj, flt,
                          ($urandom_range(0, 3) == 0));
        end

        repeat (3) @(negedge clk);
        #1 checkOutput("done_count", 32'(done_seen), 32'(exp_dones));
        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
